// File: rtl/typing_level_ctrl.sv
// Typing-game level controller: walks a ROM word key by key, tracks score, mistakes, level and lives.
// Latency: a keystroke updates char_idx/score/mistakes one cycle after key_valid; word completion reloads the timer 2 cycles later.
// Backpressure: none; key_valid is accepted only in TYPE and start only in IDLE/OVER, other strobes are dropped.
module typing_level_ctrl #(
    parameter int INIT_LIVES = 3,
    parameter int MAX_LEN    = 31
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       key_valid,
    input  logic [7:0] key_code,
    input  logic [7:0] word_len,
    input  logic [7:0] word_char,
    input  logic       timeout,
    output logic [5:0] word_sel,
    output logic [4:0] char_idx,
    output logic [7:0] num_char,
    output logic       enable_next_level,
    output logic       timer_enable,
    output logic [5:0] level,
    output logic [15:0] score,
    output logic [7:0] mistakes,
    output logic [1:0] lives,
    output logic       game_over
);

    localparam logic [7:0] MAX_LEN_C    = 8'(MAX_LEN);
    localparam logic [1:0] INIT_LIVES_C = 2'(INIT_LIVES);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        TYPE    = 3'd2,
        ADVANCE = 3'd3,
        MISS    = 3'd4,
        OVER    = 3'd5
    } state_t;

    state_t     state;
    logic       timeout_d;
    logic       timeout_edge;
    logic       key_hit;
    logic       key_miss;
    logic       last_char;
    logic [7:0] len_clamped;

    // Keystroke classification, timeout edge and word length clamp for the next LOAD.
    always_comb begin
        timeout_edge = timeout & ~timeout_d;
        key_hit      = key_valid && (key_code == word_char);
        key_miss     = key_valid && (key_code != word_char);
        last_char    = ({3'b000, char_idx} == (num_char - 8'd1));
        len_clamped  = word_len;
        if (word_len == 8'd0) begin
            len_clamped = 8'd1;
        end else if (word_len > MAX_LEN_C) begin
            len_clamped = MAX_LEN_C;
        end
    end

    // Registered copy of timeout so a held-high flag produces a single MISS.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timeout_d <= 1'b0;
        end else begin
            timeout_d <= timeout;
        end
    end

    // Game FSM; every output is a register written on the transition into the state that owns it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state             <= IDLE;
            word_sel          <= 6'd0;
            char_idx          <= 5'd0;
            num_char          <= 8'd0;
            enable_next_level <= 1'b0;
            timer_enable      <= 1'b0;
            level             <= 6'd0;
            score             <= 16'd0;
            mistakes          <= 8'd0;
            lives             <= INIT_LIVES_C;
            game_over         <= 1'b0;
        end else begin
            enable_next_level <= 1'b0;
            case (state)
                IDLE: begin
                    timer_enable <= 1'b0;
                    if (start) begin
                        state             <= LOAD;
                        enable_next_level <= 1'b1;
                    end
                end
                LOAD: begin
                    // word_sel is stable here, so the ROM length is valid for this word.
                    num_char     <= len_clamped;
                    char_idx     <= 5'd0;
                    timer_enable <= 1'b1;
                    state        <= TYPE;
                end
                TYPE: begin
                    if (key_hit) begin
                        char_idx <= char_idx + 5'd1;
                        if (score != 16'hFFFF) begin
                            score <= score + 16'd1;
                        end
                    end else if (key_miss) begin
                        if (mistakes != 8'hFF) begin
                            mistakes <= mistakes + 8'd1;
                        end
                    end
                    // Completion beats a coincident timeout edge.
                    if (key_hit && last_char) begin
                        state        <= ADVANCE;
                        timer_enable <= 1'b0;
                    end else if (timeout_edge) begin
                        state        <= MISS;
                        timer_enable <= 1'b0;
                    end
                end
                ADVANCE: begin
                    if (level != 6'd63) begin
                        level <= level + 6'd1;
                    end
                    word_sel          <= word_sel + 6'd1;
                    enable_next_level <= 1'b1;
                    state             <= LOAD;
                end
                MISS: begin
                    if (lives == 2'd1) begin
                        lives     <= 2'd0;
                        game_over <= 1'b1;
                        state     <= OVER;
                    end else begin
                        lives             <= lives - 2'd1;
                        word_sel          <= word_sel + 6'd1;
                        enable_next_level <= 1'b1;
                        state             <= LOAD;
                    end
                end
                OVER: begin
                    timer_enable <= 1'b0;
                    if (start) begin
                        score             <= 16'd0;
                        mistakes          <= 8'd0;
                        level             <= 6'd0;
                        lives             <= INIT_LIVES_C;
                        word_sel          <= 6'd0;
                        game_over         <= 1'b0;
                        enable_next_level <= 1'b1;
                        state             <= LOAD;
                    end
                end
                default: begin
                    state        <= IDLE;
                    timer_enable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_typing_level_ctrl.sv
// Bench for typing_level_ctrl: scoreboarded keystrokes against a word ROM model.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Timeout and start are driven directly to exercise miss, game-over and restart paths.
module tb_typing_level_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        key_valid;
    logic [7:0]  key_code;
    logic [7:0]  word_len;
    logic [7:0]  word_char;
    logic        timeout;
    logic [5:0]  word_sel;
    logic [4:0]  char_idx;
    logic [7:0]  num_char;
    logic        enable_next_level;
    logic        timer_enable;
    logic [5:0]  level;
    logic [15:0] score;
    logic [7:0]  mistakes;
    logic [1:0]  lives;
    logic        game_over;

    always #5 clk = ~clk;

    typing_level_ctrl #(.INIT_LIVES(3), .MAX_LEN(31)) dut (
        .clk(clk), .resetn(resetn), .start(start), .key_valid(key_valid),
        .key_code(key_code), .word_len(word_len), .word_char(word_char),
        .timeout(timeout), .word_sel(word_sel), .char_idx(char_idx),
        .num_char(num_char), .enable_next_level(enable_next_level),
        .timer_enable(timer_enable), .level(level), .score(score),
        .mistakes(mistakes), .lives(lives), .game_over(game_over)
    );

    // Word ROM: eight three-letter words, length overridable for clamp tests.
    logic [7:0] rom [0:7][0:2];
    logic       len_ovr_en = 1'b0;
    logic [7:0] len_ovr = 8'd0;

    always_comb begin
        word_len  = len_ovr_en ? len_ovr : 8'd3;
        word_char = 8'h00;
        if (char_idx < 5'd3) word_char = rom[word_sel[2:0]][char_idx[1:0]];
    end

    int en_cnt = 0;
    always @(posedge clk) if (enable_next_level) en_cnt <= en_cnt + 1;

    int n_chk = 0;
    int n_pass = 0;

    // Model state
    logic [15:0] m_score;
    logic [7:0]  m_mist;
    logic [5:0]  m_level;
    logic [5:0]  m_sel;
    logic [1:0]  m_lives;
    logic [4:0]  m_idx;
    logic [7:0]  m_num;
    logic        m_done;

    typedef struct packed {
        logic [4:0]  idx;
        logic [15:0] score;
        logic [7:0]  mist;
    } exp_t;
    exp_t exp_q[$];

    localparam logic [53:0] RESET_VEC = {6'd0, 5'd0, 8'd0, 1'b0, 1'b0, 6'd0, 16'd0, 8'd0, 2'd3, 1'b0};

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drive one keystroke, update the model and queue the expected result.
    task automatic press(input logic [7:0] k);
        logic [7:0] ec;
        exp_t e;
        ec = (m_idx < 5'd3) ? rom[m_sel[2:0]][m_idx[1:0]] : 8'h00;
        m_done = 1'b0;
        if (k == ec) begin
            if ({3'b000, m_idx} == m_num - 8'd1) m_done = 1'b1;
            m_idx   = m_idx + 5'd1;
            m_score = m_score + 16'd1;
        end else begin
            m_mist = m_mist + 8'd1;
        end
        e.idx = m_idx; e.score = m_score; e.mist = m_mist;
        exp_q.push_back(e);
        key_valid = 1'b1;
        key_code  = k;
        step();
        key_valid = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 1'b0; key_valid = 1'b0; key_code = 8'h00; timeout = 1'b0;
        step(); step();
        n_chk++;
        if ({word_sel, char_idx, num_char, enable_next_level, timer_enable, level, score,
             mistakes, lives, game_over} !== RESET_VEC)
            $display("FAIL reset_values: sel=%0d idx=%0d num=%0d en=%0b te=%0b lvl=%0d sc=%0d mi=%0d lv=%0d go=%0b expected reset values",
                     word_sel, char_idx, num_char, enable_next_level, timer_enable, level, score, mistakes, lives, game_over);
        else n_pass++;
        resetn = 1'b1;
        step(); step();
        n_chk++;
        if ({enable_next_level, timer_enable} !== 2'b00)
            $display("FAIL idle_quiet: en=%0b te=%0b expected 0 0", enable_next_level, timer_enable);
        else n_pass++;
        m_score = 0; m_mist = 0; m_level = 0; m_sel = 0; m_lives = 3; m_idx = 0; m_num = 0;
    endtask

    task automatic test_cat();
        logic [7:0] ks [0:2];
        exp_t e;
        int en0;
        ks = '{"C", "A", "T"};
        en0 = en_cnt;
        start = 1'b1; step(); start = 1'b0;
        n_chk++;
        if (enable_next_level !== 1'b1) $display("FAIL cat_load_pulse: got %0b expected 1", enable_next_level);
        else n_pass++;
        step();
        m_num = 8'd3; m_idx = 0;
        n_chk++;
        if ({num_char, timer_enable, enable_next_level} !== {8'd3, 1'b1, 1'b0})
            $display("FAIL cat_type_entry: num=%0d te=%0b en=%0b expected 3 1 0", num_char, timer_enable, enable_next_level);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            press(ks[i]);
            e = exp_q.pop_front();
            n_chk++;
            if ({char_idx, score, mistakes} !== {e.idx, e.score, e.mist})
                $display("FAIL cat_key%0d: idx=%0d sc=%0d mi=%0d expected %0d %0d %0d", i, char_idx, score, mistakes, e.idx, e.score, e.mist);
            else n_pass++;
        end
        n_chk++;
        if ({timer_enable, enable_next_level} !== 2'b00)
            $display("FAIL cat_advance: te=%0b en=%0b expected 0 0", timer_enable, enable_next_level);
        else n_pass++;
        step();
        m_level = m_level + 6'd1; m_sel = m_sel + 6'd1;
        n_chk++;
        if ({enable_next_level, level, word_sel} !== {1'b1, m_level, m_sel})
            $display("FAIL cat_reload: en=%0b lvl=%0d sel=%0d expected 1 %0d %0d", enable_next_level, level, word_sel, m_level, m_sel);
        else n_pass++;
        step();
        m_idx = 0;
        n_chk++;
        if (en_cnt - en0 !== 2) $display("FAIL cat_pulse_count: got %0d expected 2", en_cnt - en0);
        else n_pass++;
    endtask

    task automatic test_dog();
        logic [7:0] ks [0:3];
        exp_t e;
        ks = '{"D", "X", "O", "G"};
        for (int i = 0; i < 4; i++) begin
            press(ks[i]);
            e = exp_q.pop_front();
            n_chk++;
            if ({char_idx, score, mistakes} !== {e.idx, e.score, e.mist})
                $display("FAIL dog_key%0d: idx=%0d sc=%0d mi=%0d expected %0d %0d %0d", i, char_idx, score, mistakes, e.idx, e.score, e.mist);
            else n_pass++;
        end
        step();
        m_level = m_level + 6'd1; m_sel = m_sel + 6'd1;
        n_chk++;
        if ({mistakes, level, word_sel, enable_next_level} !== {8'd1, m_level, m_sel, 1'b1})
            $display("FAIL dog_done: mi=%0d lvl=%0d sel=%0d en=%0b expected 1 %0d %0d 1", mistakes, level, word_sel, enable_next_level, m_level, m_sel);
        else n_pass++;
        step();
        m_idx = 0;
    endtask

    task automatic test_timeout();
        int en0;
        en0 = en_cnt;
        timeout = 1'b1;
        step();
        n_chk++;
        if ({timer_enable, lives} !== {1'b0, 2'd3}) $display("FAIL to_miss: te=%0b lv=%0d expected 0 3", timer_enable, lives);
        else n_pass++;
        step();
        m_lives = m_lives - 2'd1; m_sel = m_sel + 6'd1;
        n_chk++;
        if ({lives, word_sel, level, enable_next_level} !== {m_lives, m_sel, m_level, 1'b1})
            $display("FAIL to_reload: lv=%0d sel=%0d lvl=%0d en=%0b expected %0d %0d %0d 1", lives, word_sel, level, enable_next_level, m_lives, m_sel, m_level);
        else n_pass++;
        step(); step(); step(); step(); step();
        m_idx = 0;
        n_chk++;
        if ({timer_enable, lives, word_sel} !== {1'b1, m_lives, m_sel})
            $display("FAIL to_held_high: te=%0b lv=%0d sel=%0d expected 1 %0d %0d", timer_enable, lives, word_sel, m_lives, m_sel);
        else n_pass++;
        n_chk++;
        if (en_cnt - en0 !== 1) $display("FAIL to_pulse_count: got %0d expected 1", en_cnt - en0);
        else n_pass++;
        timeout = 1'b0;
        step();
    endtask

    task automatic test_game_over();
        timeout = 1'b1; step(); timeout = 1'b0; step();
        m_lives = m_lives - 2'd1; m_sel = m_sel + 6'd1;
        n_chk++;
        if ({lives, enable_next_level} !== {m_lives, 1'b1})
            $display("FAIL go_second_miss: lv=%0d en=%0b expected %0d 1", lives, enable_next_level, m_lives);
        else n_pass++;
        step();
        timeout = 1'b1; step(); timeout = 1'b0; step();
        n_chk++;
        if ({lives, game_over, timer_enable, enable_next_level} !== {2'd0, 1'b1, 1'b0, 1'b0})
            $display("FAIL go_over: lv=%0d go=%0b te=%0b en=%0b expected 0 1 0 0", lives, game_over, timer_enable, enable_next_level);
        else n_pass++;
        key_valid = 1'b1; key_code = "E"; step(); key_valid = 1'b0;
        n_chk++;
        if ({score, game_over} !== {m_score, 1'b1})
            $display("FAIL go_key_ignored: sc=%0d go=%0b expected %0d 1", score, game_over, m_score);
        else n_pass++;
        start = 1'b1; step(); start = 1'b0;
        m_score = 0; m_mist = 0; m_level = 0; m_sel = 0; m_lives = 3;
        n_chk++;
        if ({lives, score, mistakes, level, word_sel, game_over, enable_next_level} !== {2'd3, 16'd0, 8'd0, 6'd0, 6'd0, 1'b0, 1'b1})
            $display("FAIL go_restart: lv=%0d sc=%0d mi=%0d lvl=%0d sel=%0d go=%0b en=%0b expected 3 0 0 0 0 0 1",
                     lives, score, mistakes, level, word_sel, game_over, enable_next_level);
        else n_pass++;
        step();
        m_idx = 0; m_num = 8'd3;
    endtask

    task automatic test_collision();
        exp_t e;
        press("C"); e = exp_q.pop_front();
        press("A"); e = exp_q.pop_front();
        n_chk++;
        if ({char_idx, score} !== {e.idx, e.score})
            $display("FAIL col_prefix: idx=%0d sc=%0d expected %0d %0d", char_idx, score, e.idx, e.score);
        else n_pass++;
        timeout = 1'b1;
        press("T");
        e = exp_q.pop_front();
        step();
        timeout = 1'b0;
        m_level = m_level + 6'd1; m_sel = m_sel + 6'd1;
        n_chk++;
        if ({level, lives, word_sel, enable_next_level, score} !== {m_level, m_lives, m_sel, 1'b1, e.score})
            $display("FAIL col_completion_wins: lvl=%0d lv=%0d sel=%0d en=%0b sc=%0d expected %0d %0d %0d 1 %0d",
                     level, lives, word_sel, enable_next_level, score, m_level, m_lives, m_sel, e.score);
        else n_pass++;
        step();
        m_idx = 0;
    endtask

    task automatic test_ignored();
        int en0;
        en0 = en_cnt;
        start = 1'b1; step(); start = 1'b0; step();
        n_chk++;
        if ({timer_enable, char_idx, word_sel, score} !== {1'b1, 5'd0, m_sel, m_score} || en_cnt != en0)
            $display("FAIL start_ignored_in_type: te=%0b idx=%0d sel=%0d sc=%0d pulses=%0d expected 1 0 %0d %0d 0",
                     timer_enable, char_idx, word_sel, score, en_cnt - en0, m_sel, m_score);
        else n_pass++;
    endtask

    task automatic test_len();
        exp_t e;
        len_ovr_en = 1'b1; len_ovr = 8'd0;
        timeout = 1'b1; step(); timeout = 1'b0; step();
        m_lives = m_lives - 2'd1; m_sel = m_sel + 6'd1;
        key_valid = 1'b1; key_code = rom[m_sel[2:0]][0]; step(); key_valid = 1'b0;
        m_idx = 0; m_num = 8'd1;
        n_chk++;
        if ({num_char, char_idx, score, lives} !== {8'd1, 5'd0, m_score, m_lives})
            $display("FAIL len_zero: num=%0d idx=%0d sc=%0d lv=%0d expected 1 0 %0d %0d", num_char, char_idx, score, lives, m_score, m_lives);
        else n_pass++;
        press(rom[m_sel[2:0]][0]);
        e = exp_q.pop_front();
        n_chk++;
        if ({score, timer_enable, m_done} !== {e.score, 1'b0, 1'b1})
            $display("FAIL len_one_char_done: sc=%0d te=%0b expected %0d 0", score, timer_enable, e.score);
        else n_pass++;
        len_ovr = 8'd40;
        step();
        m_level = m_level + 6'd1; m_sel = m_sel + 6'd1;
        step();
        m_idx = 0; m_num = 8'd31;
        n_chk++;
        if ({num_char, level, word_sel} !== {8'd31, m_level, m_sel})
            $display("FAIL len_forty: num=%0d lvl=%0d sel=%0d expected 31 %0d %0d", num_char, level, word_sel, m_level, m_sel);
        else n_pass++;
        len_ovr_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int en0;
        press(rom[m_sel[2:0]][0]);
        e = exp_q.pop_front();
        n_chk++;
        if ({char_idx, score} !== {e.idx, e.score})
            $display("FAIL rst_mid_pre: idx=%0d sc=%0d expected %0d %0d", char_idx, score, e.idx, e.score);
        else n_pass++;
        #2 resetn = 1'b0;
        #1;
        n_chk++;
        if ({word_sel, char_idx, num_char, enable_next_level, timer_enable, level, score,
             mistakes, lives, game_over} !== RESET_VEC)
            $display("FAIL rst_mid_async: sel=%0d idx=%0d num=%0d en=%0b te=%0b lvl=%0d sc=%0d mi=%0d lv=%0d go=%0b expected reset values",
                     word_sel, char_idx, num_char, enable_next_level, timer_enable, level, score, mistakes, lives, game_over);
        else n_pass++;
        en0 = en_cnt;
        step();
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) step();
        n_chk++;
        if (en_cnt != en0 || timer_enable !== 1'b0)
            $display("FAIL rst_mid_no_pulse: pulses=%0d te=%0b expected 0 0", en_cnt - en0, timer_enable);
        else n_pass++;
    endtask

    initial begin
        rom[0] = '{"C", "A", "T"}; rom[1] = '{"D", "O", "G"};
        rom[2] = '{"B", "E", "E"}; rom[3] = '{"A", "N", "T"};
        rom[4] = '{"E", "E", "L"}; rom[5] = '{"F", "O", "X"};
        rom[6] = '{"P", "I", "G"}; rom[7] = '{"R", "A", "T"};
        test_reset();
        test_cat();
        test_dog();
        test_timeout();
        test_game_over();
        test_collision();
        test_ignored();
        test_len();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
